// File: rtl/regfile_mp_if.sv
// regfile_mp_if: write, clear and read-port bundle of the register file.
// Master drives requests and addresses; slave returns data and status.
interface regfile_mp_if #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 2,
  parameter int AW     = $clog2(NREGS)
);
  logic                   clr_req;
  logic                   we;
  logic [AW-1:0]          wr_addr;
  logic [XLEN-1:0]        wr_data;
  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic                   busy;
  logic                   wr_drop;

  modport master (
    output clr_req, we, wr_addr, wr_data, rd_addr,
    input  rd_data, busy, wr_drop
  );

  modport slave (
    input  clr_req, we, wr_addr, wr_data, rd_addr,
    output rd_data, busy, wr_drop
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: NUM_RD async reads, one sync write, x0 hardwired, clear sequencer.
// Macro REGFILE_MP_BYPASS_EN adds a write-first forward from wr_data to rd_data.
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 2,
  parameter int AW     = $clog2(NREGS)
) (
  input logic         clk,
  input logic         rst_n,
  regfile_mp_if.slave rf
);
  typedef enum logic {
    CLEAR,
    READY
  } state_e;

  localparam logic [AW:0]   NREGS_W = (AW+1)'(NREGS);
  localparam logic [AW-1:0] LAST    = AW'(NREGS - 1);
  localparam logic [AW-1:0] FIRST   = AW'(1);

  state_e                 state_q;
  logic [AW-1:0]          cnt_q;
  logic                   busy_q;
  logic                   wr_drop_q;
  logic [XLEN-1:0]        mem_q [NREGS];
  logic                   wr_ok;
  logic [NUM_RD*XLEN-1:0] rd_d;

  // a write lands only when ready, not pre-empted by a clear, and in range
  assign wr_ok = rf.we & ~busy_q & ~rf.clr_req
               & (rf.wr_addr != '0)
               & ({1'b0, rf.wr_addr} < NREGS_W);

  // clear sequencer: walks cnt 1..NREGS-1, clr_req restarts it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      cnt_q     <= FIRST;
      busy_q    <= 1'b1;
      wr_drop_q <= 1'b0;
    end else begin
      wr_drop_q <= rf.we & (busy_q | rf.clr_req);
      if (rf.clr_req) begin
        state_q <= CLEAR;
        cnt_q   <= FIRST;
        busy_q  <= 1'b1;
      end else if (state_q == CLEAR) begin
        if (cnt_q == LAST) begin
          state_q <= READY;
          busy_q  <= 1'b0;
        end else begin
          cnt_q <= cnt_q + FIRST;
        end
      end
    end
  end

  // storage has no reset; the sequencer zeroes it before it is visible
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_ok) begin
      mem_q[rf.wr_addr] <= rf.wr_data;
    end
  end

  // read ports: x0, out-of-range and busy all return zero
  always_comb begin
    rd_d = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (!busy_q
          && (rf.rd_addr[i*AW +: AW] != '0)
          && ({1'b0, rf.rd_addr[i*AW +: AW]} < NREGS_W)) begin
        rd_d[i*XLEN +: XLEN] = mem_q[rf.rd_addr[i*AW +: AW]];
      end
`ifdef REGFILE_MP_BYPASS_EN
      if (wr_ok && (rf.rd_addr[i*AW +: AW] == rf.wr_addr)) begin
        rd_d[i*XLEN +: XLEN] = rf.wr_data;
      end
`endif
    end
  end

  assign rf.rd_data = rd_d;
  assign rf.busy    = busy_q;
  assign rf.wr_drop = wr_drop_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed table, corner sequences and a random model check.
// Two builds: default 32x32/2 ports and 16x64/3 ports.
module tb_regfile_mp;
`ifdef REGFILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(32), .NREGS(32), .NUM_RD(2)) b0 ();
  regfile_mp_if #(.XLEN(64), .NREGS(16), .NUM_RD(3)) b1 ();

  regfile_mp #(.XLEN(32), .NREGS(32), .NUM_RD(2)) u0 (
    .clk(clk), .rst_n(rst_n), .rf(b0)
  );
  regfile_mp #(.XLEN(64), .NREGS(16), .NUM_RD(3)) u1 (
    .clk(clk), .rst_n(rst_n), .rf(b1)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        edrop;
  } vec_t;

  vec_t tv [8];

  // reference model: contents and remaining busy cycles
  logic [31:0] mreg [32];
  int          mbusy;
  logic        mdrop;

  function automatic logic [31:0] mrd(input logic [4:0] ra, input bit busy,
                                      input bit clr, input bit we,
                                      input logic [4:0] wa,
                                      input logic [31:0] wd);
    if (busy) return 32'h0;
    if (BYP && we && !clr && wa != 5'd0 && ra == wa) return wd;
    if (ra == 5'd0) return 32'h0;
    return mreg[ra];
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int c0;
    int c1;
    bit clr;
    bit we;
    bit bsy;
    logic [4:0] wa;
    logic [4:0] ra0;
    logic [4:0] ra1;
    logic [31:0] wd;

    b0.clr_req = 0; b0.we = 0; b0.wr_addr = 0; b0.wr_data = 0;
    b0.rd_addr = {5'd31, 5'd5};
    b1.clr_req = 0; b1.we = 0; b1.wr_addr = 0; b1.wr_data = 0;
    b1.rd_addr = {4'd15, 4'd15, 4'd1};

    // reset state
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_busy0", 64'(b0.busy), 64'd1);
    chk("rst_busy1", 64'(b1.busy), 64'd1);
    chk("rst_drop0", 64'(b0.wr_drop), 64'd0);
    chk("rst_rd0", b0.rd_data, 64'd0);
    chk("rst_rd1a", b1.rd_data[63:0], 64'd0);
    chk("rst_rd1c", b1.rd_data[191:128], 64'd0);

    // release; write to x3 in the first cycle is dropped
    rst_n = 1'b1;
    b0.we = 1; b0.wr_addr = 5'd3; b0.wr_data = 32'h55;
    n = 0; c0 = 0; c1 = 0;
    while ((b0.busy || b1.busy) && n < 100) begin
      b0.rd_addr = {5'(n + 1), 5'(n)};
      b1.rd_addr = {4'(n), 4'(n + 1), 4'(n + 2)};
      #1;
      if (b0.busy) chk("clr_rd0", b0.rd_data, 64'd0);
      if (b1.busy) chk("clr_rd1", b1.rd_data[63:0], 64'd0);
      c0 += int'(b0.busy);
      c1 += int'(b1.busy);
      n++;
      tick();
      if (n == 1) begin
        chk("busy_wr_drop", 64'(b0.wr_drop), 64'd1);
        b0.we = 0;
      end
    end
    chk("rst_timeout", 64'(n < 100), 64'd1);
    chk("rst_busy_len0", 64'(c0), 64'd31);
    chk("rst_busy_len1", 64'(c1), 64'd15);
    b0.rd_addr = {5'd0, 5'd3};
    #1;
    chk("x3_dropped", b0.rd_data, 64'd0);
    chk("drop_cleared", 64'(b0.wr_drop), 64'd0);

    // directed table
    tv[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0,
              BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 1'b0};
    tv[1] = '{1'b1, 5'd0, 32'h1234, 5'd5, 5'd0,
              32'hDEADBEEF, 32'h0, 1'b0};
    tv[2] = '{1'b0, 5'd0, 32'h0, 5'd5, 5'd0,
              32'hDEADBEEF, 32'h0, 1'b0};
    tv[3] = '{1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7,
              BYP ? 32'hA5A5A5A5 : 32'h0,
              BYP ? 32'hA5A5A5A5 : 32'h0, 1'b0};
    tv[4] = '{1'b0, 5'd0, 32'h0, 5'd7, 5'd5,
              32'hA5A5A5A5, 32'hDEADBEEF, 1'b0};
    tv[5] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd1,
              BYP ? 32'hCAFEF00D : 32'h0, 32'h0, 1'b0};
    tv[6] = '{1'b1, 5'd1, 32'h11111111, 5'd31, 5'd1,
              32'hCAFEF00D, BYP ? 32'h11111111 : 32'h0, 1'b0};
    tv[7] = '{1'b0, 5'd0, 32'h0, 5'd1, 5'd31,
              32'h11111111, 32'hCAFEF00D, 1'b0};
    for (int i = 0; i < 8; i++) begin
      b0.we = tv[i].we;
      b0.wr_addr = tv[i].wa;
      b0.wr_data = tv[i].wd;
      b0.rd_addr = {tv[i].ra1, tv[i].ra0};
      #1;
      chk($sformatf("tv%0d_p0", i), 64'(b0.rd_data[31:0]), 64'(tv[i].e0));
      chk($sformatf("tv%0d_p1", i), 64'(b0.rd_data[63:32]), 64'(tv[i].e1));
      chk($sformatf("tv%0d_drop", i), 64'(b0.wr_drop), 64'(tv[i].edrop));
      tick();
    end
    b0.we = 0;

    // clear request with a colliding write to x9
    for (int a = 1; a < 32; a++) begin
      b0.we = 1; b0.wr_addr = 5'(a); b0.wr_data = 32'hFFFFFFFF;
      tick();
    end
    b0.clr_req = 1; b0.we = 1; b0.wr_addr = 5'd9; b0.wr_data = 32'h12;
    b0.rd_addr = {5'd31, 5'd9};
    #1;
    chk("pre_clr_x9", b0.rd_data, 64'hFFFFFFFF_FFFFFFFF);
    chk("pre_clr_busy", 64'(b0.busy), 64'd0);
    tick();
    b0.clr_req = 0; b0.we = 0;
    chk("clr_wr_drop", 64'(b0.wr_drop), 64'd1);
    n = 0;
    while (b0.busy && n < 100) begin
      n++;
      tick();
    end
    chk("clr_busy_len", 64'(n), 64'd31);
    for (int a = 0; a < 32; a++) begin
      b0.rd_addr = {5'(a), 5'(a)};
      #1;
      chk($sformatf("after_clr_x%0d", a), b0.rd_data, 64'd0);
    end

    // wide build
    b1.we = 1; b1.wr_addr = 4'd15; b1.wr_data = 64'h0123456789ABCDEF;
    tick();
    b1.we = 0;
    b1.rd_addr = {4'd15, 4'd15, 4'd15};
    #1;
    chk("p_x15_p0", b1.rd_data[63:0], 64'h0123456789ABCDEF);
    chk("p_x15_p1", b1.rd_data[127:64], 64'h0123456789ABCDEF);
    chk("p_x15_p2", b1.rd_data[191:128], 64'h0123456789ABCDEF);
    b1.rd_addr = {4'd0, 4'd15, 4'd0};
    #1;
    chk("p_x0_p0", b1.rd_data[63:0], 64'd0);
    chk("p_mix_p1", b1.rd_data[127:64], 64'h0123456789ABCDEF);
    chk("p_x0_p2", b1.rd_data[191:128], 64'd0);
    tick();

    // random stimulus against the model
    for (int a = 0; a < 32; a++) mreg[a] = 32'h0;
    mbusy = 0;
    mdrop = 1'b0;
    for (int k = 0; k < 800; k++) begin
      clr = ($urandom_range(0, 39) == 0);
      we = 1'($urandom_range(0, 1));
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      ra0 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      b0.clr_req = clr; b0.we = we; b0.wr_addr = wa; b0.wr_data = wd;
      b0.rd_addr = {ra1, ra0};
      #1;
      bsy = (mbusy > 0);
      chk("rnd_rd0", 64'(b0.rd_data[31:0]),
          64'(mrd(ra0, bsy, clr, we, wa, wd)));
      chk("rnd_rd1", 64'(b0.rd_data[63:32]),
          64'(mrd(ra1, bsy, clr, we, wa, wd)));
      chk("rnd_busy", 64'(b0.busy), 64'(bsy));
      chk("rnd_drop", 64'(b0.wr_drop), 64'(mdrop));
      mdrop = we && (bsy || clr);
      if (clr) begin
        for (int a = 0; a < 32; a++) mreg[a] = 32'h0;
        mbusy = 31;
      end else if (mbusy > 0) begin
        mbusy--;
      end else if (we && wa != 5'd0) begin
        mreg[wa] = wd;
      end
      tick();
    end
    b0.clr_req = 0; b0.we = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
